// File: rtl/dual_port_ram_pkg.sv
// -----------------------------------------------------------------------------
// ram_pkg
// Shared types and constants for the dual_port_ram block.
//   ram_state_t : clearing FSM states (ST_INIT, ST_READY)
//   RD_LATENCY  : read latency in clock cycles; 2 when RAM_OUT_REG_EN is
//                 defined (extra output register), otherwise 1.
// -----------------------------------------------------------------------------
package ram_pkg;

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } ram_state_t;

`ifdef RAM_OUT_REG_EN
    localparam int RD_LATENCY = 32'd2;
`else
    localparam int RD_LATENCY = 32'd1;
`endif

endpackage : ram_pkg

// File: rtl/dual_port_ram_if.sv
// -----------------------------------------------------------------------------
// dual_port_ram_if
// Bus between the client arbiter (master) and the dual-port RAM (slave).
//   RD_EN / RD_ADDR                : read request and address (master -> slave)
//   WR_EN / WR_ADDR / WR_DATA      : write request, address, data (master -> slave)
//   ERR_CLR                        : clears the sticky ACCESS_ERR (master -> slave)
//   RD_DATA / RD_VALID             : read result and strobe (slave -> master)
//   INIT_DONE                      : array clearing finished (slave -> master)
//   ACCESS_ERR                     : sticky access-during-clear flag (slave -> master)
// -----------------------------------------------------------------------------
interface dual_port_ram_if #(
    parameter int G_ADDR_WIDTH = 32'd4,
    parameter int G_DATA_WIDTH = 32'd8
);

    logic                    RD_EN;
    logic [G_ADDR_WIDTH-1:0] RD_ADDR;
    logic                    WR_EN;
    logic [G_ADDR_WIDTH-1:0] WR_ADDR;
    logic [G_DATA_WIDTH-1:0] WR_DATA;
    logic                    ERR_CLR;
    logic [G_DATA_WIDTH-1:0] RD_DATA;
    logic                    RD_VALID;
    logic                    INIT_DONE;
    logic                    ACCESS_ERR;

    modport master (
        output RD_EN, RD_ADDR, WR_EN, WR_ADDR, WR_DATA, ERR_CLR,
        input  RD_DATA, RD_VALID, INIT_DONE, ACCESS_ERR
    );

    modport slave (
        input  RD_EN, RD_ADDR, WR_EN, WR_ADDR, WR_DATA, ERR_CLR,
        output RD_DATA, RD_VALID, INIT_DONE, ACCESS_ERR
    );

endinterface : dual_port_ram_if

// File: rtl/dual_port_ram_init_seq.sv
// -----------------------------------------------------------------------------
// ram_init_seq
// Post-reset clearing sequencer. Walks a counter over every array address,
// requesting a clear write at each, then parks in ST_READY with INIT_DONE high.
//   CLOCK        : system clock, rising edge
//   RST_N        : asynchronous active-low reset; restarts clearing at address 0
//   o_clr_we     : clear write enable to the array mux (high in ST_INIT)
//   o_clr_addr   : clear write address
//   o_init_done  : registered, high once the last address has been cleared
// -----------------------------------------------------------------------------
module ram_init_seq
    import ram_pkg::*;
#(
    parameter int G_ADDR_WIDTH = 32'd4
) (
    input  logic                    CLOCK,
    input  logic                    RST_N,
    output logic                    o_clr_we,
    output logic [G_ADDR_WIDTH-1:0] o_clr_addr,
    output logic                    o_init_done
);

    localparam logic [G_ADDR_WIDTH-1:0] C_ZERO = {G_ADDR_WIDTH{1'b0}};
    localparam logic [G_ADDR_WIDTH-1:0] C_LAST = {G_ADDR_WIDTH{1'b1}};
    localparam logic [G_ADDR_WIDTH-1:0] C_ONE  = G_ADDR_WIDTH'(1'b1);

    ram_state_t              r_state;
    ram_state_t              w_state_nxt;
    logic [G_ADDR_WIDTH-1:0] r_count;
    logic [G_ADDR_WIDTH-1:0] w_count_nxt;
    logic                    r_init_done;
    logic                    w_init_done_nxt;

    // State, counter and INIT_DONE registers
    always_ff @(posedge CLOCK or negedge RST_N) begin
        if (!RST_N) begin
            r_state     <= ST_INIT;
            r_count     <= C_ZERO;
            r_init_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_count     <= w_count_nxt;
            r_init_done <= w_init_done_nxt;
        end
    end

    // Next-state logic: count through all addresses, leave ST_INIT on the last
    always_comb begin
        w_state_nxt     = r_state;
        w_count_nxt     = r_count;
        w_init_done_nxt = r_init_done;
        case (r_state)
            ST_INIT: begin
                // Counter wraps back to zero on the final clear write
                w_count_nxt = r_count + C_ONE;
                if (r_count == C_LAST) begin
                    w_state_nxt     = ST_READY;
                    w_init_done_nxt = 1'b1;
                end else begin
                    w_state_nxt     = ST_INIT;
                    w_init_done_nxt = 1'b0;
                end
            end
            ST_READY: begin
                w_state_nxt     = ST_READY;
                w_init_done_nxt = 1'b1;
            end
            default: begin
                w_state_nxt     = ST_INIT;
                w_count_nxt     = C_ZERO;
                w_init_done_nxt = 1'b0;
            end
        endcase
    end

    assign o_clr_we    = (r_state == ST_INIT);
    assign o_clr_addr  = r_count;
    assign o_init_done = r_init_done;

endmodule : ram_init_seq

// File: rtl/dual_port_ram.sv
// -----------------------------------------------------------------------------
// dual_port_ram
// Simple dual-port synchronous RAM behind the client arbiter. After each reset
// the array is overwritten with G_INIT_VALUE before INIT_DONE rises. Same-
// address read/write on one edge is write-first (bypass). Any request seen
// while clearing is dropped and sets the sticky ACCESS_ERR.
//   CLOCK : system clock, rising edge
//   RST_N : asynchronous active-low reset
//   bus   : dual_port_ram_if.slave (RD_*, WR_*, ERR_CLR in; RD_DATA,
//           RD_VALID, INIT_DONE, ACCESS_ERR out)
// Configuration macro RAM_OUT_REG_EN: adds an output register after the
// array read (read latency 2 instead of 1); RD_VALID is delayed with the data.
// -----------------------------------------------------------------------------
module dual_port_ram
    import ram_pkg::*;
#(
    parameter int                      G_ADDR_WIDTH = 32'd4,
    parameter int                      G_DATA_WIDTH = 32'd8,
    parameter logic [G_DATA_WIDTH-1:0] G_INIT_VALUE = {G_DATA_WIDTH{1'b0}}
) (
    input  logic            CLOCK,
    input  logic            RST_N,
    dual_port_ram_if.slave  bus
);

    localparam int                      C_DEPTH     = 32'd1 << G_ADDR_WIDTH;
    localparam logic [G_DATA_WIDTH-1:0] C_DATA_ZERO = {G_DATA_WIDTH{1'b0}};

    logic [G_DATA_WIDTH-1:0] r_mem [C_DEPTH];

    logic                    w_clr_we;
    logic [G_ADDR_WIDTH-1:0] w_clr_addr;
    logic                    w_init_done;

    logic                    w_wr_fire;
    logic                    w_rd_fire;
    logic                    w_viol;
    logic [G_DATA_WIDTH-1:0] w_rd_word;

    logic [G_DATA_WIDTH-1:0] r_rd_data;
    logic                    r_rd_valid;
    logic                    r_access_err;

    ram_init_seq #(
        .G_ADDR_WIDTH (G_ADDR_WIDTH)
    ) u_init_seq (
        .CLOCK       (CLOCK),
        .RST_N       (RST_N),
        .o_clr_we    (w_clr_we),
        .o_clr_addr  (w_clr_addr),
        .o_init_done (w_init_done)
    );

    // Request qualification and write-first read data selection
    always_comb begin
        w_wr_fire = bus.WR_EN & w_init_done;
        w_rd_fire = bus.RD_EN & w_init_done;
        w_viol    = (bus.RD_EN | bus.WR_EN) & ~w_init_done;
        if (w_wr_fire && (bus.WR_ADDR == bus.RD_ADDR)) begin
            w_rd_word = bus.WR_DATA;
        end else begin
            w_rd_word = r_mem[bus.RD_ADDR];
        end
    end

    // Array write port: clear writes own the port until INIT_DONE
    always_ff @(posedge CLOCK) begin
        if (w_clr_we) begin
            r_mem[w_clr_addr] <= G_INIT_VALUE;
        end else if (w_wr_fire) begin
            r_mem[bus.WR_ADDR] <= bus.WR_DATA;
        end
    end

    // First read stage: data holds when no read is issued
    always_ff @(posedge CLOCK or negedge RST_N) begin
        if (!RST_N) begin
            r_rd_data  <= C_DATA_ZERO;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_fire;
            if (w_rd_fire) begin
                r_rd_data <= w_rd_word;
            end
        end
    end

    // Sticky access error: a new violation wins over ERR_CLR
    always_ff @(posedge CLOCK or negedge RST_N) begin
        if (!RST_N) begin
            r_access_err <= 1'b0;
        end else if (w_viol) begin
            r_access_err <= 1'b1;
        end else if (bus.ERR_CLR) begin
            r_access_err <= 1'b0;
        end
    end

`ifdef RAM_OUT_REG_EN
    logic [G_DATA_WIDTH-1:0] r_out_data;
    logic                    r_out_valid;

    // Optional output register stage; bypass data follows the same path
    always_ff @(posedge CLOCK or negedge RST_N) begin
        if (!RST_N) begin
            r_out_data  <= C_DATA_ZERO;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= r_rd_valid;
            if (r_rd_valid) begin
                r_out_data <= r_rd_data;
            end
        end
    end

    assign bus.RD_DATA  = r_out_data;
    assign bus.RD_VALID = r_out_valid;
`else
    assign bus.RD_DATA  = r_rd_data;
    assign bus.RD_VALID = r_rd_valid;
`endif

    assign bus.INIT_DONE  = w_init_done;
    assign bus.ACCESS_ERR = r_access_err;

endmodule : dual_port_ram

// File: tb/tb_dual_port_ram.sv
// -----------------------------------------------------------------------------
// tb_dual_port_ram
// Self-checking bench for dual_port_ram (default parameters). Directed vectors
// in a table plus hand-written sequences for clearing, reset and streaming.
// -----------------------------------------------------------------------------
module tb_dual_port_ram;
    import ram_pkg::*;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int L  = RD_LATENCY;
    localparam int NV = 12;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    dual_port_ram_if #(.G_ADDR_WIDTH(AW), .G_DATA_WIDTH(DW)) bus ();

    dual_port_ram #(
        .G_ADDR_WIDTH (AW),
        .G_DATA_WIDTH (DW),
        .G_INIT_VALUE (8'h00)
    ) dut (
        .CLOCK (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rd_en;
        logic [3:0] rd_addr;
        logic       wr_en;
        logic [3:0] wr_addr;
        logic [7:0] wr_data;
        logic       err_clr;
        logic       exp_valid;
        logic [7:0] exp_data;
        logic       exp_err;
    } vec_t;

    vec_t vecs[NV];

    function automatic vec_t mk(input logic rd_en, input logic [3:0] rd_addr,
                                input logic wr_en, input logic [3:0] wr_addr,
                                input logic [7:0] wr_data, input logic err_clr,
                                input logic exp_valid, input logic [7:0] exp_data,
                                input logic exp_err);
        vec_t v;
        v.rd_en = rd_en; v.rd_addr = rd_addr; v.wr_en = wr_en;
        v.wr_addr = wr_addr; v.wr_data = wr_data; v.err_clr = err_clr;
        v.exp_valid = exp_valid; v.exp_data = exp_data; v.exp_err = exp_err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rd_en, input logic [3:0] rd_addr,
                         input logic wr_en, input logic [3:0] wr_addr,
                         input logic [7:0] wr_data, input logic err_clr);
        bus.RD_EN   = rd_en;
        bus.RD_ADDR = rd_addr;
        bus.WR_EN   = wr_en;
        bus.WR_ADDR = wr_addr;
        bus.WR_DATA = wr_data;
        bus.ERR_CLR = err_clr;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // {rd_en, rd_addr, wr_en, wr_addr, wr_data, err_clr, exp_valid, exp_data, exp_err}
        vecs[0]  = mk(1'b0, 4'd0, 1'b1, 4'd3, 8'hA5, 1'b0, 1'b0, 8'h00, 1'b1);
        vecs[1]  = mk(1'b1, 4'd3, 1'b0, 4'd0, 8'h00, 1'b0, 1'b1, 8'hA5, 1'b1);
        vecs[2]  = mk(1'b0, 4'd0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b1);
        vecs[3]  = mk(1'b0, 4'd0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 8'hA5, 1'b0);
        vecs[4]  = mk(1'b1, 4'd7, 1'b1, 4'd7, 8'h3C, 1'b0, 1'b1, 8'h3C, 1'b0);
        vecs[5]  = mk(1'b1, 4'd6, 1'b1, 4'd7, 8'h5A, 1'b0, 1'b1, 8'h00, 1'b0);
        vecs[6]  = mk(1'b1, 4'd7, 1'b0, 4'd0, 8'h00, 1'b0, 1'b1, 8'h5A, 1'b0);
        vecs[7]  = mk(1'b0, 4'd0, 1'b1, 4'd6, 8'h66, 1'b0, 1'b0, 8'h5A, 1'b0);
        vecs[8]  = mk(1'b1, 4'd6, 1'b0, 4'd0, 8'h00, 1'b0, 1'b1, 8'h66, 1'b0);
        vecs[9]  = mk(1'b1, 4'd3, 1'b1, 4'd9, 8'hFF, 1'b0, 1'b1, 8'hA5, 1'b0);
        vecs[10] = mk(1'b1, 4'd0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0);
        vecs[11] = mk(1'b1, 4'd9, 1'b0, 4'd0, 8'h00, 1'b0, 1'b1, 8'hFF, 1'b0);

        drive(1'b0, 4'd0, 1'b0, 4'd0, 8'h00, 1'b0);
        rst_n = 1'b0;
        repeat (2) tick();
        chk("reset_rd_data",    bus.RD_DATA,           8'h00);
        chk("reset_rd_valid",   {7'd0, bus.RD_VALID},   8'h00);
        chk("reset_init_done",  {7'd0, bus.INIT_DONE},  8'h00);
        chk("reset_access_err", {7'd0, bus.ACCESS_ERR}, 8'h00);
        rst_n = 1'b1;

        // First clearing pass with a read attempted on edge 5
        for (int e = 1; e <= 16; e++) begin
            drive((e == 5), 4'd2, 1'b0, 4'd0, 8'h00, 1'b0);
            tick();
            chk($sformatf("init1_done_e%0d", e), {7'd0, bus.INIT_DONE}, {7'd0, (e == 16)});
            chk($sformatf("init1_err_e%0d", e), {7'd0, bus.ACCESS_ERR}, {7'd0, (e >= 5)});
            if (e == 5) chk("init1_rd_valid_e5", {7'd0, bus.RD_VALID}, 8'h00);
        end

        // Table: vector i is driven before edge i; its read result is due L-1 edges later
        for (int i = 0; i < NV + L - 1; i++) begin
            if (i < NV) begin
                drive(vecs[i].rd_en, vecs[i].rd_addr, vecs[i].wr_en,
                      vecs[i].wr_addr, vecs[i].wr_data, vecs[i].err_clr);
            end else begin
                drive(1'b0, 4'd0, 1'b0, 4'd0, 8'h00, 1'b0);
            end
            tick();
            if (i < NV) chk($sformatf("vec%0d_err", i), {7'd0, bus.ACCESS_ERR}, {7'd0, vecs[i].exp_err});
            if (i >= L - 1) begin
                chk($sformatf("vec%0d_valid", i - L + 1), {7'd0, bus.RD_VALID},
                    {7'd0, vecs[i - L + 1].exp_valid});
                chk($sformatf("vec%0d_data", i - L + 1), bus.RD_DATA, vecs[i - L + 1].exp_data);
            end
        end
        drive(1'b0, 4'd0, 1'b0, 4'd0, 8'h00, 1'b0);
        tick();
        chk("idle_valid", {7'd0, bus.RD_VALID}, 8'h00);
        chk("idle_hold",  bus.RD_DATA,          8'hFF);

        // Reset in the middle of a pending write
        drive(1'b0, 4'd0, 1'b1, 4'd9, 8'hAB, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_rd_data",   bus.RD_DATA,           8'h00);
        chk("midrst_rd_valid",  {7'd0, bus.RD_VALID},   8'h00);
        chk("midrst_init_done", {7'd0, bus.INIT_DONE},  8'h00);
        tick();
        drive(1'b0, 4'd0, 1'b0, 4'd0, 8'h00, 1'b0);
        rst_n = 1'b1;

        // Second clearing pass: violation, violation+clear, clear alone
        for (int e = 1; e <= 16; e++) begin
            drive(1'b0, 4'd0, (e == 2) || (e == 3), 4'd5, 8'h11, (e == 3) || (e == 4));
            tick();
            chk($sformatf("init2_done_e%0d", e), {7'd0, bus.INIT_DONE}, {7'd0, (e == 16)});
            chk($sformatf("init2_err_e%0d", e), {7'd0, bus.ACCESS_ERR}, {7'd0, (e == 2) || (e == 3)});
        end

        // Streaming read of the freshly cleared array
        for (int k = 0; k < 16 + L; k++) begin
            drive((k < 16), k[3:0], 1'b0, 4'd0, 8'h00, 1'b0);
            tick();
            if (k >= L - 1 && k - L + 1 < 16) begin
                chk($sformatf("clr_rd%0d_valid", k - L + 1), {7'd0, bus.RD_VALID}, 8'h01);
                chk($sformatf("clr_rd%0d_data", k - L + 1), bus.RD_DATA, 8'h00);
            end
        end
        chk("clr_stream_end_valid", {7'd0, bus.RD_VALID}, 8'h00);

        // Fill with distinct data, then stream in address order
        for (int k = 0; k < 16; k++) begin
            drive(1'b0, 4'd0, 1'b1, k[3:0], 8'h10 + k[7:0], 1'b0);
            tick();
        end
        for (int k = 0; k < 16 + L; k++) begin
            drive((k < 16), k[3:0], 1'b0, 4'd0, 8'h00, 1'b0);
            tick();
            if (k >= L - 1 && k - L + 1 < 16) begin
                chk($sformatf("seq_rd%0d_valid", k - L + 1), {7'd0, bus.RD_VALID}, 8'h01);
                chk($sformatf("seq_rd%0d_data", k - L + 1), bus.RD_DATA, 8'h10 + 8'(k - L + 1));
            end
        end
        chk("seq_stream_end_valid", {7'd0, bus.RD_VALID}, 8'h00);
        chk("seq_final_err", {7'd0, bus.ACCESS_ERR}, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_dual_port_ram

// File: doc/dual_port_ram.md
# dual_port_ram

Simple dual-port synchronous RAM that sits directly downstream of the client arbiter and consumes its RD_EN/RD_ADDR and WR_EN/WR_ADDR/WR_DATA outputs, returning RD_DATA. After every reset it runs a self-clearing sequence that writes G_INIT_VALUE to every location and then raises INIT_DONE. It also provides same-address write-first bypass, a read-valid strobe, and a sticky error flag for accesses attempted during clearing.

## Interface
- G_ADDR_WIDTH, 4, address width; depth = 2**G_ADDR_WIDTH.
- G_DATA_WIDTH, 8, data word width.
- G_INIT_VALUE, 0, word written to every location during clearing.

- CLOCK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- RD_EN  in  1  read request, sampled on the rising edge.
- RD_ADDR  in  G_ADDR_WIDTH  read address.
- WR_EN  in  1  write request, sampled on the rising edge.
- WR_ADDR  in  G_ADDR_WIDTH  write address.
- WR_DATA  in  G_DATA_WIDTH  write data.
- ERR_CLR  in  1  clears ACCESS_ERR.
- RD_DATA  out  G_DATA_WIDTH  read data.
- RD_VALID  out  1  one-cycle strobe; RD_DATA carries a new read result.
- INIT_DONE  out  1  high once clearing completes; low during reset and clearing.
- ACCESS_ERR  out  1  sticky; set by RD_EN or WR_EN sampled high while INIT_DONE is low.

## Operation
- Reset values: RD_DATA=0, RD_VALID=0, INIT_DONE=0, ACCESS_ERR=0, clear counter=0, state ST_INIT. Array contents are not reset asynchronously; clearing rewrites them.
- FSM ST_INIT: each edge writes G_INIT_VALUE to mem[count] and increments count. On the edge that writes address 2**G_ADDR_WIDTH-1, the FSM moves to ST_READY and INIT_DONE goes high. The counter wraps to 0.
- FSM ST_READY: terminal state. Only reset leaves it.
- In ST_INIT, RD_EN and WR_EN are ignored. The array is not touched by them, RD_VALID stays low, and ACCESS_ERR is set.
- ST_READY write: on the edge with WR_EN=1, mem[WR_ADDR] <= WR_DATA.
- ST_READY read: on the edge with RD_EN=1, RD_DATA <= mem[RD_ADDR] and RD_VALID <= 1. Otherwise RD_VALID <= 0 and RD_DATA holds its value.
- Simultaneous RD_EN and WR_EN with RD_ADDR==WR_ADDR: write-first, so RD_DATA <= WR_DATA. With different addresses, the read returns the old contents.
- ACCESS_ERR: set has priority over ERR_CLR in the same cycle. It clears only when ERR_CLR=1 and no new violation occurs in that cycle.
- Reset asserted mid-operation: all outputs return to their reset values immediately. On release, clearing restarts from address 0, and any write in flight is discarded.

## Timing
- Clearing: INIT_DONE rises after the 2**G_ADDR_WIDTH-th rising edge following RST_N release. The default is 16 edges.
- Read latency: 1 cycle. Address sampled at edge k gives data on RD_DATA after edge k, with RD_VALID high for the cycle between edges k and k+1.
- Write: visible to a read of the same address at the same edge (bypass) and at any later edge.
- Back-to-back reads on every edge give RD_VALID continuously high.

## Configuration
- RAM_OUT_REG_EN defined: an extra output register follows the array read. Read latency becomes 2, and RD_VALID is delayed together with RD_DATA. Bypass data passes through the same register, so ordering is preserved.
- RAM_OUT_REG_EN undefined: read latency is 1, as above.
- ACCESS_ERR and INIT_DONE timing are unaffected either way.

## Structure
- Package ram_pkg holds:
  - typedef ram_state_t {ST_INIT, ST_READY}
  - localparam RD_LATENCY (1 or 2, selected by RAM_OUT_REG_EN)
- Sub-module ram_init_seq contains the FSM, clear counter and INIT_DONE generation. It outputs the clear write enable and address to the array mux in dual_port_ram.

## Test plan
- Reset release, default params -> INIT_DONE low for 15 edges and high after edge 16. Reads of addresses 0..15 all return 0x00.
- Write 0xA5 to addr 3, read addr 3 next edge -> RD_DATA=0xA5 with RD_VALID high exactly one cycle, 1 cycle after the read edge (2 with RAM_OUT_REG_EN).
- Same-edge WR_EN=1 addr 7 data 0x3C and RD_EN=1 addr 7 (old content 0x00) -> RD_DATA=0x3C. Repeat with RD_ADDR=6 -> old mem[6] is returned.
- RD_EN=1 on edge 5 of clearing -> ACCESS_ERR=1 and RD_VALID stays 0. ERR_CLR pulsed after INIT_DONE -> ACCESS_ERR=0. ERR_CLR and a violation in the same cycle -> ACCESS_ERR stays 1.
- Write 0xFF to addr 9, then assert RST_N low mid-stream -> outputs go to 0 immediately. After re-clearing, addr 9 reads 0x00.
- Continuous reads of addr 0..15 on consecutive edges -> RD_VALID stays high and data appears in address order at the fixed latency.
